// File: rtl/tick_countdown.sv
// tick_countdown: turns the slow clk_sys_in square wave into one-cycle ticks
// and runs a loadable countdown timer, counted in slow periods, on those ticks.
module tick_countdown #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_sys_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             cancel,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             expired,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, edge_p, done_n;
  logic [CNT_W-1:0] rem_n, eff;
  // The timer acts on the same edge that raises tick, so tick, done and the last decrement line up.
  assign edge_p = sync[SYNC_STAGES-1] & ~prev;
  assign eff = load ? load_val : remaining;
  assign busy = state == RUN;
  assign expired = state == EXPIRED;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
      remaining <= '0;
      done <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_sys_in};
      prev <= sync[SYNC_STAGES-1];
      tick <= edge_p;
      remaining <= rem_n;
      done <= done_n;
      state <= state_n;
    end
  end
  always_comb begin
    state_n = state;
    rem_n = remaining;
    done_n = 1'b0;
    case (state)
      IDLE: if (!cancel) begin
        rem_n = eff;
        if (start) begin
          state_n = (eff == '0) ? EXPIRED : RUN;
          done_n = eff == '0;
        end
      end
      RUN: if (cancel) state_n = IDLE;
      else if (edge_p) begin
        rem_n = (remaining > ONE) ? remaining - ONE : '0;
        state_n = (remaining > ONE) ? RUN : EXPIRED;
        done_n = remaining <= ONE;
      end
      EXPIRED: if (cancel) state_n = IDLE;
      else if (load) begin
        rem_n = load_val;
        state_n = IDLE;
      end else done_n = start;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tick_countdown.sv
// tb_tick_countdown: directed stimulus, per-cycle comparison against a rule-level model
module tb_tick_countdown;
  localparam int N = 2;
  localparam int W = 8;
  logic clk = 0, rst = 1, clk_sys_in = 0, load = 0, start = 0, cancel = 0;
  logic [W-1:0] load_val = '0;
  logic tick, busy, expired, done;
  logic [W-1:0] remaining;
  int checks = 0, passes = 0;
  bit sys_en = 0, live = 0;
  int sys_cnt = 0;
  bit samp [0:N] = '{default: 0};
  int m_state = 0;
  logic [W-1:0] m_rem = '0;
  logic m_tick = 0, m_done = 0;

  tick_countdown #(.SYNC_STAGES(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .clk_sys_in(clk_sys_in), .load(load), .load_val(load_val),
    .start(start), .cancel(cancel), .tick(tick), .busy(busy), .remaining(remaining),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sys_en) begin
    if (sys_cnt == 0) clk_sys_in = ~clk_sys_in;
    sys_cnt = (sys_cnt == 4) ? 0 : sys_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: 0 idle, 1 counting, 2 expired. A rise is seen once it has crossed N sampling flops.
  always @(posedge clk) begin
    bit p;
    p = samp[N-1] && !samp[N];
    if (rst) begin
      for (int i = 0; i <= N; i++) samp[i] = 0;
      m_state = 0; m_rem = '0; m_tick = 0; m_done = 0; live = 1;
    end else begin
      for (int i = N; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = clk_sys_in;
      m_tick = p;
      m_done = 0;
      if (m_state == 0) begin
        if (!cancel) begin
          if (load) m_rem = load_val;
          if (start) begin
            if (m_rem == 0) begin m_state = 2; m_done = 1; end
            else m_state = 1;
          end
        end
      end else if (m_state == 1) begin
        if (cancel) m_state = 0;
        else if (p) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_state = 2; m_done = 1; end
        end
      end else begin
        if (cancel) m_state = 0;
        else if (load) begin m_rem = load_val; m_state = 0; end
        else if (start) m_done = 1;
      end
    end
  end

  always @(negedge clk) if (live) begin
    check("tick", tick, m_tick);
    check("busy", busy, m_state == 1);
    check("expired", expired, m_state == 2);
    check("remaining", remaining, m_rem);
    check("done", done, m_done);
  end

  task automatic run_until_expired(output int n, output logic [31:0] seq, output int dones);
    int last = -1;
    bit ok = 0;
    n = 0; seq = '0; dones = 0;
    for (int i = 0; i < 300; i++) begin
      if (int'(remaining) != last) begin
        seq = {seq[23:0], remaining};
        n++;
        last = int'(remaining);
      end
      if (done) dones++;
      if (expired) begin ok = 1; break; end
      @(negedge clk);
    end
    check("expire_timeout", ok, 1);
  endtask

  task automatic wait_for(input logic [W-1:0] rem, input bit pulse_next);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_state == 1 && m_rem == rem && (samp[N-1] && !samp[N]) == pulse_next) begin ok = 1; break; end
    end
    check("wait_timeout", ok, 1);
  endtask

  initial begin
    int first, cnt, n, dones;
    logic [31:0] seq;
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_remaining", remaining, 0);
    check("rst_tick", tick, 0);
    @(posedge clk) #1 sys_en = 1;
    // Idle: tick 3 clk after first sampled rise, then every 10 clk
    first = -1; cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (tick) begin
        if (first < 0) first = i;
        else if (cnt == 1) check("tick_period", i - first, 10);
        cnt++;
      end
      @(negedge clk);
    end
    check("tick_latency", first, 3);
    check("tick_count", cnt, 3);
    check("idle_busy", busy, 0);
    // Normal countdown from 3
    load = 1; load_val = 3;
    @(negedge clk) load = 0; start = 1;
    @(negedge clk) start = 0;
    check("run_busy", busy, 1);
    run_until_expired(n, seq, dones);
    check("cd3_seq", seq, 32'h03020100);
    check("cd3_len", n, 4);
    check("cd3_done", dones, 1);
    check("cd3_busy", busy, 0);
    // Zero start and simultaneous load+start
    @(negedge clk) cancel = 1;
    @(negedge clk) cancel = 0; load = 1; start = 1; load_val = 0;
    @(negedge clk) load = 0; start = 0;
    check("zero_expired", expired, 1);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk) check("zero_done_once", done, 0);
    cancel = 1;
    @(negedge clk) cancel = 0; load = 1; start = 1; load_val = 5;
    @(negedge clk) load = 0; start = 0;
    check("ls5_busy", busy, 1);
    check("ls5_rem", remaining, 5);
    // Cancel coinciding with a tick at remaining 2
    wait_for(2, 1);
    cancel = 1;
    @(negedge clk) cancel = 0;
    check("cancel_busy", busy, 0);
    check("cancel_rem", remaining, 2);
    check("cancel_done", done, 0);
    check("cancel_tick", tick, 1);
    start = 1;
    @(negedge clk) start = 0;
    run_until_expired(n, seq, dones);
    check("resume_seq", seq, 32'h00020100);
    check("resume_len", n, 3);
    check("resume_done", dones, 1);
    // Load ignored while running; load in expired returns to idle
    @(negedge clk) cancel = 1;
    @(negedge clk) cancel = 0; load = 1; start = 1; load_val = 6;
    @(negedge clk) load = 0; start = 0;
    wait_for(4, 0);
    load = 1; load_val = 9;
    @(negedge clk) load = 0;
    check("ign_rem", remaining, 4);
    check("ign_busy", busy, 1);
    run_until_expired(n, seq, dones);
    check("ign_seq", seq, 32'h03020100);
    check("ign_len", n, 5);
    load = 1; load_val = 7;
    @(negedge clk) load = 0;
    check("exp_load_rem", remaining, 7);
    check("exp_load_expired", expired, 0);
    check("exp_load_busy", busy, 0);
    // Reset in the middle of a countdown, on a tick cycle
    start = 1;
    @(negedge clk) start = 0;
    wait_for(6, 1);
    rst = 1;
    @(negedge clk) rst = 0;
    check("mid_rst_tick", tick, 0);
    check("mid_rst_rem", remaining, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_expired", expired, 0);
    check("mid_rst_done", done, 0);
    // Full-scale load value
    repeat (5) @(negedge clk);
    load = 1; start = 1; load_val = 8'hff;
    @(negedge clk) load = 0; start = 0;
    check("max_rem", remaining, 8'hff);
    wait_for(8'hfe, 0);
    check("max_dec", remaining, 8'hfe);
    cancel = 1;
    @(negedge clk) cancel = 0;
    repeat (25) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
